// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, state encoding and opcode helper for the fetch stage
package fetch_stage_pkg;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h1800;
  localparam logic [4:0] HALT_OPC = 5'b00000;
  localparam logic [15:0] ALIGN_MASK = 16'h0001;
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HELD = 2'd2, HALTED = 2'd3} fetchState_t;
  function automatic logic isHalt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPC;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus
interface fetch_stage_if;
  logic IMemRd;
  logic [15:0] IMemAddr;
  logic IMemDone;
  logic [15:0] IMemData;
  modport master(output IMemRd, IMemAddr, input IMemDone, IMemData);
  modport slave(input IMemRd, IMemAddr, output IMemDone, IMemData);
endinterface

// File: rtl/dff.sv
// dff: parameterised register with synchronous active-high reset to a fixed value
module dff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // state register
  always_ff @(posedge clk) q <= rst ? RST : d;
endmodule

// File: rtl/fetch_stage_hold_buf.sv
// fetch_hold_buf: parks a delivered {instr, pcinc} pair while decode is stalled
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] instrIn,
  input  logic [15:0] pcIncIn,
  output logic [15:0] instrOut,
  output logic [15:0] pcIncOut,
  output logic        valid
);
  // clear wins over load so a redirect never leaves a stale entry behind
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      instrOut <= '0;
      pcIncOut <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instrOut <= instrIn;
      pcIncOut <= pcIncIn;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, talks to a stalling instruction memory and feeds IF/ID
import fetch_stage_pkg::*;
module fetch_stage (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        mem,
  input  logic                 PCWrite,
  input  logic                 Redirect,
  input  logic [15:0]          RedirectPC,
  output logic [15:0]          Instr_Out_ToD,
  output logic [15:0]          PCInc_Out_ToD,
  output logic                 FetchValid,
  output logic                 Halted,
  output logic                 AlignErr
);
  logic [15:0] pc, pcNext, pcInc, holdInstr, holdPcInc;
  logic [1:0] stateQ;
  fetchState_t state, stateNext;
  logic squash, squashNext, alignNext, holdValid, holdLoad, holdClear;
  logic issue, deliver, heldOut;
  dff #(.W(16), .RST(RESET_PC)) pcReg (.clk(clk), .rst(rst), .d(pcNext), .q(pc));
  dff #(.W(2), .RST(2'(FETCH))) stateReg (.clk(clk), .rst(rst), .d(stateNext), .q(stateQ));
  dff #(.W(1), .RST(1'b0)) squashReg (.clk(clk), .rst(rst), .d(squashNext), .q(squash));
  dff #(.W(1), .RST(1'b0)) alignReg (.clk(clk), .rst(rst), .d(alignNext), .q(AlignErr));
  fetch_hold_buf holdBuf (
    .clk(clk), .rst(rst), .load(holdLoad), .clear(holdClear),
    .instrIn(mem.IMemData), .pcIncIn(pcInc),
    .instrOut(holdInstr), .pcIncOut(holdPcInc), .valid(holdValid)
  );
  assign state = fetchState_t'(stateQ);
  assign pcInc = pc + 16'd2;
  assign issue = state == FETCH && (pc & ALIGN_MASK) == 16'd0;
  assign deliver = !rst && !Redirect && mem.IMemDone && (issue || (state == WAIT && !squash));
  assign heldOut = !rst && !Redirect && state == HELD && holdValid;
  assign mem.IMemRd = !rst && !Redirect && issue;
  assign mem.IMemAddr = pc;
  assign FetchValid = deliver || heldOut;
  assign Instr_Out_ToD = deliver ? mem.IMemData : heldOut ? holdInstr : NOP_INSTR;
  assign PCInc_Out_ToD = heldOut ? holdPcInc : pcInc;
  assign Halted = !rst && state == HALTED;
  // next PC/state: redirect first, then delivery, then release of a held word, then idle transitions
  always_comb begin
    pcNext = pc;
    stateNext = state;
    squashNext = squash;
    alignNext = AlignErr;
    holdLoad = 1'b0;
    holdClear = 1'b0;
    if (Redirect) begin
      pcNext = RedirectPC;
      holdClear = 1'b1;
      squashNext = state == WAIT && !mem.IMemDone;
      stateNext = squashNext ? WAIT : FETCH;
    end else if (deliver) begin
      pcNext = PCWrite ? pcInc : pc;
      holdLoad = !PCWrite;
      stateNext = !PCWrite ? HELD : isHalt(mem.IMemData) ? HALTED : FETCH;
    end else if (heldOut && PCWrite) begin
      pcNext = pcInc;
      holdClear = 1'b1;
      stateNext = isHalt(holdInstr) ? HALTED : FETCH;
    end else if (state == FETCH) begin
      stateNext = issue ? WAIT : HALTED;
      alignNext = AlignErr || !issue;
    end else if (state == WAIT && squash && mem.IMemDone) begin
      squashNext = 1'b0;
      stateNext = FETCH;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage hits, misses, stalls, redirects, halt and boundaries
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic PCWrite = 1'b0;
  logic Redirect = 1'b0;
  logic [15:0] RedirectPC = '0;
  logic [15:0] Instr_Out_ToD, PCInc_Out_ToD;
  logic FetchValid, Halted, AlignErr;
  int passCnt = 0;
  int totalCnt = 0;
  fetch_stage_if memIf ();
  fetch_stage dut (
    .clk(clk), .rst(rst), .mem(memIf.master), .PCWrite(PCWrite), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .Instr_Out_ToD(Instr_Out_ToD), .PCInc_Out_ToD(PCInc_Out_ToD),
    .FetchValid(FetchValid), .Halted(Halted), .AlignErr(AlignErr)
  );
  always #5 clk = ~clk;
  initial begin
    memIf.IMemDone = 1'b0;
    memIf.IMemData = '0;
  end
  task automatic cyc(input logic r, input logic pw, input logic red, input logic [15:0] rpc,
                     input logic dn, input logic [15:0] dat);
    @(negedge clk);
    rst = r;
    PCWrite = pw;
    Redirect = red;
    RedirectPC = rpc;
    memIf.IMemDone = dn;
    memIf.IMemData = dat;
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  initial begin
    cyc(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("rst_instr", Instr_Out_ToD, 16'h1800);
    chk("rst_valid", FetchValid, 0);
    chk("rst_rd", memIf.IMemRd, 0);
    chk("rst_halted", Halted, 0);
    cyc(0, 1, 0, 16'h0000, 1, 16'hC001);
    chk("hit1_rd", memIf.IMemRd, 1);
    chk("hit1_addr", memIf.IMemAddr, 16'h0000);
    chk("hit1_instr", Instr_Out_ToD, 16'hC001);
    chk("hit1_pcinc", PCInc_Out_ToD, 16'h0002);
    chk("hit1_valid", FetchValid, 1);
    chk("rst_align", AlignErr, 0);
    cyc(0, 1, 0, 16'h0000, 1, 16'hC002);
    chk("hit2_addr", memIf.IMemAddr, 16'h0002);
    chk("hit2_instr", Instr_Out_ToD, 16'hC002);
    chk("hit2_pcinc", PCInc_Out_ToD, 16'h0004);
    chk("hit2_valid", FetchValid, 1);
    cyc(0, 1, 1, 16'h0010, 0, 16'h0000);
    chk("hit3_addr", memIf.IMemAddr, 16'h0004);
    chk("redir_rd", memIf.IMemRd, 0);
    chk("redir_valid", FetchValid, 0);
    chk("redir_instr", Instr_Out_ToD, 16'h1800);
    cyc(0, 1, 0, 16'h0000, 0, 16'h0000);
    chk("miss_rd", memIf.IMemRd, 1);
    chk("miss_addr", memIf.IMemAddr, 16'h0010);
    chk("miss_b1_valid", FetchValid, 0);
    cyc(0, 1, 0, 16'h0000, 0, 16'h0000);
    chk("miss_b2_rd", memIf.IMemRd, 0);
    chk("miss_b2_valid", FetchValid, 0);
    chk("miss_b2_addr", memIf.IMemAddr, 16'h0010);
    cyc(0, 1, 0, 16'h0000, 1, 16'hA5A5);
    chk("miss_done_rd", memIf.IMemRd, 0);
    chk("miss_done_instr", Instr_Out_ToD, 16'hA5A5);
    chk("miss_done_pcinc", PCInc_Out_ToD, 16'h0012);
    chk("miss_done_valid", FetchValid, 1);
    cyc(0, 0, 0, 16'h0000, 1, 16'hD123);
    chk("stall_d_rd", memIf.IMemRd, 1);
    chk("stall_d_instr", Instr_Out_ToD, 16'hD123);
    chk("stall_d_pcinc", PCInc_Out_ToD, 16'h0014);
    cyc(0, 0, 0, 16'h0000, 0, 16'h0000);
    chk("stall_h1_rd", memIf.IMemRd, 0);
    chk("stall_h1_instr", Instr_Out_ToD, 16'hD123);
    chk("stall_h1_pcinc", PCInc_Out_ToD, 16'h0014);
    chk("stall_h1_valid", FetchValid, 1);
    chk("stall_h1_pc", memIf.IMemAddr, 16'h0012);
    cyc(0, 1, 0, 16'h0000, 0, 16'h0000);
    chk("stall_h2_rd", memIf.IMemRd, 0);
    chk("stall_h2_instr", Instr_Out_ToD, 16'hD123);
    chk("stall_h2_valid", FetchValid, 1);
    cyc(0, 1, 1, 16'h0020, 0, 16'h0000);
    chk("stall_adv_pc", memIf.IMemAddr, 16'h0014);
    cyc(0, 1, 0, 16'h0000, 0, 16'h0000);
    chk("sq_rd", memIf.IMemRd, 1);
    chk("sq_addr", memIf.IMemAddr, 16'h0020);
    cyc(0, 1, 1, 16'h0100, 0, 16'h0000);
    chk("sq_redir_valid", FetchValid, 0);
    cyc(0, 1, 0, 16'h0000, 1, 16'hBEEF);
    chk("sq_drop_valid", FetchValid, 0);
    chk("sq_drop_instr", Instr_Out_ToD, 16'h1800);
    chk("sq_drop_rd", memIf.IMemRd, 0);
    cyc(0, 1, 0, 16'h0000, 1, 16'h1234);
    chk("sq_new_rd", memIf.IMemRd, 1);
    chk("sq_new_addr", memIf.IMemAddr, 16'h0100);
    chk("sq_new_instr", Instr_Out_ToD, 16'h1234);
    chk("sq_new_pcinc", PCInc_Out_ToD, 16'h0102);
    cyc(0, 1, 1, 16'h0030, 0, 16'h0000);
    cyc(0, 1, 0, 16'h0000, 1, 16'h0000);
    chk("halt_valid", FetchValid, 1);
    chk("halt_instr", Instr_Out_ToD, 16'h0000);
    chk("halt_pcinc", PCInc_Out_ToD, 16'h0032);
    chk("halt_pre", Halted, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 16'h0000, 1, 16'h5555);
      chk("halted", Halted, 1);
      chk("halted_rd", memIf.IMemRd, 0);
      chk("halted_valid", FetchValid, 0);
      chk("halted_pc", memIf.IMemAddr, 16'h0032);
    end
    cyc(0, 1, 1, 16'h0040, 0, 16'h0000);
    chk("halt_redir_valid", FetchValid, 0);
    cyc(0, 1, 0, 16'h0000, 1, 16'h4444);
    chk("resume_halted", Halted, 0);
    chk("resume_rd", memIf.IMemRd, 1);
    chk("resume_addr", memIf.IMemAddr, 16'h0040);
    chk("resume_instr", Instr_Out_ToD, 16'h4444);
    cyc(0, 1, 1, 16'h0005, 0, 16'h0000);
    cyc(0, 1, 0, 16'h0000, 1, 16'h6666);
    chk("odd_rd", memIf.IMemRd, 0);
    chk("odd_valid", FetchValid, 0);
    chk("odd_align_pre", AlignErr, 0);
    cyc(0, 1, 0, 16'h0000, 0, 16'h0000);
    chk("odd_align", AlignErr, 1);
    chk("odd_halted", Halted, 1);
    chk("odd_rd2", memIf.IMemRd, 0);
    cyc(0, 1, 1, 16'hFFFE, 0, 16'h0000);
    cyc(0, 1, 0, 16'h0000, 1, 16'h7777);
    chk("wrap_addr", memIf.IMemAddr, 16'hFFFE);
    chk("wrap_instr", Instr_Out_ToD, 16'h7777);
    chk("wrap_pcinc", PCInc_Out_ToD, 16'h0000);
    chk("align_sticky", AlignErr, 1);
    cyc(0, 1, 0, 16'h0000, 0, 16'h0000);
    chk("wrap_next_addr", memIf.IMemAddr, 16'h0000);
    chk("wrap_next_rd", memIf.IMemRd, 1);
    cyc(0, 1, 1, 16'h0050, 0, 16'h0000);
    cyc(0, 1, 0, 16'h0000, 0, 16'h0000);
    chk("rw_addr", memIf.IMemAddr, 16'h0050);
    chk("rw_rd", memIf.IMemRd, 0);
    cyc(1, 1, 0, 16'h0000, 0, 16'h0000);
    chk("rw_rst_valid", FetchValid, 0);
    chk("rw_rst_instr", Instr_Out_ToD, 16'h1800);
    cyc(0, 1, 0, 16'h0000, 0, 16'h0000);
    chk("post_rst_addr", memIf.IMemAddr, 16'h0000);
    chk("post_rst_rd", memIf.IMemRd, 1);
    chk("post_rst_align", AlignErr, 0);
    chk("post_rst_halted", Halted, 0);
    chk("post_rst_valid", FetchValid, 0);
    cyc(0, 1, 0, 16'h0000, 1, 16'h9999);
    chk("post_rst_instr", Instr_Out_ToD, 16'h9999);
    chk("post_rst_dvalid", FetchValid, 1);
    chk("post_rst_pcinc", PCInc_Out_ToD, 16'h0002);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
